cp_command_broadcaster: RTL and testbench

Control-processor-side transmitter for the CP→VP command broadcast bus. It accepts command requests from the control processor and drives the bus, one broadcast word or a sequence of per-VP unicast words. Each word is held for exactly one cycle, because every VP control unit enqueues into its input FIFO on every cycle the bus addresses it. It honours the OR-reduced VP FIFO-full signal and enforces a minimum inter-command gap. It sits between the control processor and all VP control units.

---
 rtl/cp_command_broadcaster_pkg.sv | 46 ++++
 rtl/cp_command_broadcaster_upcounter.sv | 23 ++
 rtl/cp_command_broadcaster.sv | 145 ++++++++++++++
 tb/tb_cp_command_broadcaster.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cp_command_broadcaster_pkg.sv
// Shared definitions for the CP->VP command broadcast bus.
// Word layout (CBC_BUS_WIDTH = 16):
//   [5:0]   CP_MSG_OPERATION  opcode
//   [9:6]   CP_MSG_DST        destination VP id (VPID_NONE = all ones = nobody)
//   [10]    CP_MSG_BCAST      1 = every VP takes the word
//   [15:11] reserved, always 0
package cp_command_broadcaster_pkg;

  localparam int VPID_WIDTH       = 4;
  localparam int CBC_BUS_WIDTH    = 16;
  localparam int CP_MSG_OP_LSB    = 0;
  localparam int CP_MSG_OP_W      = 6;
  localparam int CP_MSG_DST_LSB   = 6;
  localparam int CP_MSG_BCAST_BIT = 10;

  typedef logic [VPID_WIDTH-1:0]    vpid_t;
  typedef logic [CP_MSG_OP_W-1:0]   cp_op_t;
  typedef logic [CBC_BUS_WIDTH-1:0] cbc_word_t;

  // The all-ones id is reserved for the idle word, so no VP may use it.
  localparam vpid_t VPID_NONE = '1;

  localparam cp_op_t VP_COMMAND_START_MAIN_THREAD = 6'h01;
  localparam cp_op_t VP_COMMAND_STOP_MAIN_THREAD  = 6'h02;

  typedef enum logic [1:0] {
    CPB_STATE_IDLE      = 2'd0,
    CPB_STATE_WAIT_BUSY = 2'd1,
    CPB_STATE_GAP       = 2'd2,
    CPB_STATE_FINISH    = 2'd3
  } cpb_state_e;

  // Idle word: everything zero except DST = VPID_NONE, so no VP enqueues it.
  localparam cbc_word_t CP_IDLE_WORD = cbc_word_t'(
    {{(CBC_BUS_WIDTH-CP_MSG_DST_LSB-VPID_WIDTH){1'b0}}, VPID_NONE, {CP_MSG_DST_LSB{1'b0}}});

  function automatic cbc_word_t cp_msg_word(input logic bcast, input vpid_t dst, input cp_op_t op);
    cbc_word_t w;
    w = '0;
    w[CP_MSG_BCAST_BIT]                = bcast;
    w[CP_MSG_DST_LSB +: VPID_WIDTH]    = dst;
    w[CP_MSG_OP_LSB +: CP_MSG_OP_W]    = op;
    return w;
  endfunction

endpackage

// File: rtl/cp_command_broadcaster_upcounter.sv
// Free-running up-counter with synchronous load of an initial value on reset.
// Ports: Clock, Reset (sync, active low), Enable (count this edge),
//        Initial (reset value), Q (count, wraps modulo 2^WIDTH).
module cp_command_broadcaster_upcounter #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Initial,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge Clock) begin
    if (!Reset)      count_q <= Initial;
    else if (Enable) count_q <= count_q + 1'b1;
  end

  assign Q = count_q;

endmodule

// File: rtl/cp_command_broadcaster.sv
// CP-side transmitter for the CP->VP command broadcast bus.
// Accepts one request at a time and drives either a single broadcast word or a
// run of unicast words to consecutive VPs, each held on the bus for exactly one
// cycle and followed by GAP_CYCLES idle bus cycles.
// Ports:
//   Clock, Reset (sync, active low)
//   iRequestValid / oRequestReady      request handshake (ready only in IDLE)
//   iRequestBroadcast, iRequestOperation, iRequestFirstVP, iRequestCount
//   iVpBusy       OR of all VP input-FIFO full flags, sampled in WAIT_BUSY
//   oCpCommand    registered bus word
//   oDone         one-cycle completion pulse
//   oRangeError   with oDone: the run hit VPID_NONE and was cut short
//   oIssuedCount  words issued since reset, wraps at 2^16
module cp_command_broadcaster
  import cp_command_broadcaster_pkg::*;
#(
  parameter int GAP_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iRequestValid,
  output logic                  oRequestReady,
  input  logic                  iRequestBroadcast,
  input  logic [CP_MSG_OP_W-1:0] iRequestOperation,
  input  logic [VPID_WIDTH-1:0] iRequestFirstVP,
  input  logic [VPID_WIDTH:0]   iRequestCount,
  input  logic                  iVpBusy,
  output logic [CBC_BUS_WIDTH-1:0] oCpCommand,
  output logic                  oDone,
  output logic                  oRangeError,
  output logic [15:0]           oIssuedCount
);

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

  cpb_state_e          state_q, state_d;
  cp_op_t              op_q, op_d;
  vpid_t               dst_q, dst_d;
  logic [VPID_WIDTH:0] cnt_q, cnt_d;
  logic                bcast_q, bcast_d;
  logic                trunc_q, trunc_d;
  logic [3:0]          gap_q, gap_d;
  cbc_word_t           cmd_q, cmd_d;
  logic                issue;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    dst_d         = dst_q;
    cnt_d         = cnt_q;
    bcast_d       = bcast_q;
    trunc_d       = trunc_q;
    gap_d         = gap_q;
    cmd_d         = cmd_q;
    issue         = 1'b0;
    oRequestReady = 1'b0;
    oDone         = 1'b0;
    oRangeError   = 1'b0;
    case (state_q)
      CPB_STATE_IDLE: begin
        oRequestReady = 1'b1;
        if (iRequestValid) begin
          op_d    = iRequestOperation;
          bcast_d = iRequestBroadcast;
          // Broadcast ignores destination/count: one word, DST field zero.
          dst_d   = iRequestBroadcast ? '0 : iRequestFirstVP;
          cnt_d   = iRequestBroadcast ? (VPID_WIDTH+1)'(1) : iRequestCount;
          state_d = (iRequestBroadcast || iRequestCount != '0) ? CPB_STATE_WAIT_BUSY
                                                               : CPB_STATE_FINISH;
        end
      end
      CPB_STATE_WAIT_BUSY: begin
        if (!iVpBusy) begin
          if (!bcast_q && dst_q == VPID_NONE) begin
            trunc_d = 1'b1;
            state_d = CPB_STATE_FINISH;
          end else begin
            cmd_d   = cp_msg_word(bcast_q, dst_q, op_q);
            cnt_d   = cnt_q - 1'b1;
            gap_d   = GAP_INIT;
            issue   = 1'b1;
            state_d = CPB_STATE_GAP;
          end
        end
      end
      CPB_STATE_GAP: begin
        cmd_d = CP_IDLE_WORD;
        // Every word is followed by GAP_CYCLES idle bus cycles. Going on to
        // another word, the WAIT_BUSY cycle is itself one of those idle cycles,
        // so leave GAP one cycle earlier than when heading for FINISH.
        if (cnt_q != '0) begin
          if (gap_q <= 4'd1) begin
            dst_d   = dst_q + 1'b1;
            state_d = CPB_STATE_WAIT_BUSY;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end else begin
          if (gap_q == 4'd0) state_d = CPB_STATE_FINISH;
          else               gap_d   = gap_q - 1'b1;
        end
      end
      CPB_STATE_FINISH: begin
        oDone       = 1'b1;
        oRangeError = trunc_q;
        trunc_d     = 1'b0;
        state_d     = CPB_STATE_IDLE;
      end
      default: state_d = CPB_STATE_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= CPB_STATE_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      bcast_q <= 1'b0;
      trunc_q <= 1'b0;
      gap_q   <= '0;
      cmd_q   <= CP_IDLE_WORD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      bcast_q <= bcast_d;
      trunc_q <= trunc_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
    end
  end

  assign oCpCommand = cmd_q;

  cp_command_broadcaster_upcounter #(.WIDTH(16)) u_issued_cnt (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (issue),
    .Initial (16'd0),
    .Q       (oIssuedCount)
  );

endmodule

// File: tb/tb_cp_command_broadcaster.sv
module tb_cp_command_broadcaster;
  import cp_command_broadcaster_pkg::*;

  localparam int GAP   = 4;
  localparam int LIMIT = 600;

  logic      Clock = 1'b0;
  logic      Reset;
  logic      iRequestValid, iRequestBroadcast, iVpBusy;
  cp_op_t    iRequestOperation;
  vpid_t     iRequestFirstVP;
  logic [VPID_WIDTH:0] iRequestCount;
  logic      oRequestReady, oDone, oRangeError;
  cbc_word_t oCpCommand;
  logic [15:0] oIssuedCount;

  always #5 Clock = ~Clock;

  cp_command_broadcaster #(.GAP_CYCLES(GAP)) dut (
    .Clock(Clock), .Reset(Reset),
    .iRequestValid(iRequestValid), .oRequestReady(oRequestReady),
    .iRequestBroadcast(iRequestBroadcast), .iRequestOperation(iRequestOperation),
    .iRequestFirstVP(iRequestFirstVP), .iRequestCount(iRequestCount),
    .iVpBusy(iVpBusy), .oCpCommand(oCpCommand), .oDone(oDone),
    .oRangeError(oRangeError), .oIssuedCount(oIssuedCount)
  );

  int n_pass = 0, n_total = 0;
  int exp_issued = 0;
  bit busy_arr [0:1023];

  // observed and expected traces; cycle k = k-th cycle after the acceptance edge
  int        obs_cyc[$], exp_cyc[$];
  cbc_word_t obs_word[$], exp_word[$];
  int        obs_done, exp_done;
  logic      obs_rerr, exp_rerr;

  localparam cbc_word_t DST_MASK = cbc_word_t'({VPID_WIDTH{1'b1}}) << CP_MSG_DST_LSB;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  // Reference: every word waits for busy low, appears the cycle after, and is
  // followed by GAP idle bus cycles before the next word or before oDone.
  // A unicast destination that would reach VPID_NONE ends the run with an error.
  task automatic model(input logic b, input cp_op_t op, input vpid_t first, input int cnt);
    int t, n, d;
    exp_cyc.delete(); exp_word.delete();
    exp_rerr = 1'b0;
    n = b ? 1 : cnt;
    if (n == 0) begin exp_done = 1; return; end
    t = 1;
    for (int i = 0; i < n; i++) begin
      while (busy_arr[t]) t++;
      d = int'(first) + i;
      if (!b && d >= 15) begin
        exp_done = t + 1; exp_rerr = 1'b1; return;
      end
      exp_cyc.push_back(t + 1);
      exp_word.push_back(cp_msg_word(b, b ? vpid_t'(0) : vpid_t'(d), op));
      if (i < n - 1) t = t + 1 + GAP;
      else exp_done = t + 1 + GAP + 1;
    end
  endtask

  task automatic run_req(input logic b, input cp_op_t op, input vpid_t first, input logic [4:0] cnt);
    int k;
    bit done_seen;
    iRequestValid = 1'b1; iRequestBroadcast = b; iRequestOperation = op;
    iRequestFirstVP = first; iRequestCount = cnt;
    check("ready_before_accept", {31'd0, oRequestReady}, 1);
    tick();
    iRequestValid = 1'b0;
    obs_cyc.delete(); obs_word.delete();
    obs_done = -1; obs_rerr = 1'b0; done_seen = 0;
    for (k = 1; k <= LIMIT; k++) begin
      iVpBusy = busy_arr[k];
      if (oCpCommand !== CP_IDLE_WORD) begin
        obs_cyc.push_back(k); obs_word.push_back(oCpCommand);
      end
      if (oRangeError === 1'b1 && oDone !== 1'b1) check("rerr_without_done", 1, 0);
      if (oDone === 1'b1) begin
        obs_done = k; obs_rerr = oRangeError; done_seen = 1; break;
      end
      tick();
    end
    iVpBusy = 1'b0;
    if (!done_seen) check("done_timeout", 0, 1);
    tick();
    check("ready_after_done", {31'd0, oRequestReady}, 1);
  endtask

  task automatic compare_model(input string tag, input logic b);
    int n;
    check({tag, "_nwords"}, obs_cyc.size(), exp_cyc.size());
    n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_word_cycle"}, obs_cyc[i], exp_cyc[i]);
      if (b) check({tag, "_bcast_word"}, {16'd0, obs_word[i] & ~DST_MASK}, {16'd0, exp_word[i]});
      else   check({tag, "_word"}, {16'd0, obs_word[i]}, {16'd0, exp_word[i]});
    end
    check({tag, "_done_cycle"}, obs_done, exp_done);
    check({tag, "_rerr"}, {31'd0, obs_rerr}, {31'd0, exp_rerr});
    exp_issued += exp_cyc.size();
    check({tag, "_issued"}, {16'd0, oIssuedCount}, exp_issued & 16'hffff);
  endtask

  typedef struct {
    logic   b;
    cp_op_t op;
    vpid_t  first;
    logic [4:0] cnt;
    int     busy_len;
    int     nwords;
    int     first_cyc;
    int     done_cyc;
    logic   rerr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, VP_COMMAND_START_MAIN_THREAD, 4'd7,  5'd0, 0,  1, 2,  7,  1'b0};
    vecs[1] = '{1'b0, VP_COMMAND_STOP_MAIN_THREAD,  4'd2,  5'd3, 0,  3, 2,  17, 1'b0};
    vecs[2] = '{1'b0, VP_COMMAND_START_MAIN_THREAD, 4'd5,  5'd1, 10, 1, 12, 17, 1'b0};
    vecs[3] = '{1'b0, VP_COMMAND_STOP_MAIN_THREAD,  4'd14, 5'd3, 0,  1, 2,  7,  1'b1};
    vecs[4] = '{1'b0, VP_COMMAND_START_MAIN_THREAD, 4'd3,  5'd0, 0,  0, 0,  1,  1'b0};
    vecs[5] = '{1'b0, VP_COMMAND_START_MAIN_THREAD, 4'd15, 5'd2, 0,  0, 0,  2,  1'b1};
    vecs[6] = '{1'b1, VP_COMMAND_STOP_MAIN_THREAD,  4'd0,  5'd9, 3,  1, 5,  10, 1'b0};

    Reset = 1'b0; iRequestValid = 1'b0; iRequestBroadcast = 1'b0; iVpBusy = 1'b0;
    iRequestOperation = '0; iRequestFirstVP = '0; iRequestCount = '0;
    tick(); tick();
    check("reset_cmd",    {16'd0, oCpCommand}, {16'd0, CP_IDLE_WORD});
    check("reset_done",   {31'd0, oDone}, 0);
    check("reset_rerr",   {31'd0, oRangeError}, 0);
    check("reset_issued", {16'd0, oIssuedCount}, 0);
    Reset = 1'b1;
    tick();
    check("reset_ready",  {31'd0, oRequestReady}, 1);

    // directed table
    foreach (vecs[v]) begin
      for (int i = 0; i < 1024; i++) busy_arr[i] = (i >= 1 && i <= vecs[v].busy_len);
      model(vecs[v].b, vecs[v].op, vecs[v].first, int'(vecs[v].cnt));
      run_req(vecs[v].b, vecs[v].op, vecs[v].first, vecs[v].cnt);
      check("tbl_nwords", obs_cyc.size(), vecs[v].nwords);
      if (vecs[v].nwords > 0) check("tbl_first_cycle", obs_cyc[0], vecs[v].first_cyc);
      check("tbl_done_cycle", obs_done, vecs[v].done_cyc);
      check("tbl_rerr", {31'd0, obs_rerr}, {31'd0, vecs[v].rerr});
      compare_model("tbl", vecs[v].b);
    end

    // randomized requests and busy patterns
    for (int r = 0; r < 40; r++) begin
      logic b; cp_op_t op; vpid_t first; logic [4:0] cnt;
      for (int i = 0; i < 1024; i++) busy_arr[i] = (i >= 1) && ($urandom_range(0, 3) == 0);
      b     = ($urandom_range(0, 3) == 0);
      op    = cp_op_t'($urandom);
      first = vpid_t'($urandom_range(0, 15));
      cnt   = 5'($urandom_range(0, 6));
      model(b, op, first, int'(cnt));
      run_req(b, op, first, cnt);
      compare_model("rnd", b);
    end

    // reset during the GAP after the second word of a count-5 run
    iRequestValid = 1'b1; iRequestBroadcast = 1'b0;
    iRequestOperation = VP_COMMAND_START_MAIN_THREAD; iRequestFirstVP = 4'd0; iRequestCount = 5'd5;
    iVpBusy = 1'b0;
    tick();
    iRequestValid = 1'b0;
    for (int k = 1; k < 7; k++) tick();
    check("rst_seq_second_word", {16'd0, oCpCommand},
          {16'd0, cp_msg_word(1'b0, 4'd1, VP_COMMAND_START_MAIN_THREAD)});
    tick();
    Reset = 1'b0;
    tick();
    check("rst_seq_cmd",    {16'd0, oCpCommand}, {16'd0, CP_IDLE_WORD});
    check("rst_seq_issued", {16'd0, oIssuedCount}, 0);
    check("rst_seq_done",   {31'd0, oDone}, 0);
    Reset = 1'b1;
    #1;
    check("rst_seq_ready", {31'd0, oRequestReady}, 1);
    for (int k = 0; k < 15; k++) begin
      tick();
      if (oDone !== 1'b0 || oCpCommand !== CP_IDLE_WORD) begin
        check("rst_seq_quiet", {15'd0, oDone, oCpCommand}, {16'd0, CP_IDLE_WORD});
        break;
      end
    end
    check("rst_seq_issued_after", {16'd0, oIssuedCount}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
